// File: rtl/dff_bank_write_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM state encoding.
package dff_bank_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/dff_bank_write_arbiter_dff_reg_en_clr.sv
// Storage register with async active-low reset, synchronous clear and load enable.
// Clear has priority over load so a clear cycle can never be overridden by stale data.
module dff_reg_en_clr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: reset, then clear, then load; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write arbiter for one shared register. Each load takes an IDLE
// (arbitrate) cycle plus a WRITE cycle; a level clear takes IDLE plus CLEAR.
// The winner is latched in IDLE and re-checked in WRITE so a requester that
// drops its request before being served leaves the register untouched.
module dff_bank_write_arbiter
  import dff_bank_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                         clk,
  input  logic                         async_reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    wdata,
  input  logic                         clear,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         clear_done,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   last_id,
  output logic [DATA_W-1:0]            reg_q
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   pick_id;
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [DATA_W-1:0] load_data;
  logic              load_en;
  logic              clr_en;

  // First asserted request at or above ptr, wrapping; scanning from the far
  // end backwards lets the nearest candidate overwrite the others.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] sel;
    int              idx;
    sel = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (r[idx]) begin
        sel = ID_W'(idx);
      end
    end
    return sel;
  endfunction

  // Unpack the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  assign pick_id   = rr_pick(req, rr_ptr);
  assign load_data = wdata_arr[win_id];
  assign load_en   = (state == ST_WRITE) && req[win_id];
  assign clr_en    = (state == ST_CLEAR);
  assign busy      = (state != ST_IDLE);

  // Arbitration FSM with registered grant/clear pulses and round-robin pointer.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      win_id     <= '0;
      gnt        <= '0;
      clear_done <= 1'b0;
      last_id    <= '0;
    end else begin
      gnt        <= '0;
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear) begin
            state <= ST_CLEAR;
          end else if (|req) begin
            win_id <= pick_id;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (req[win_id]) begin
            gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            last_id <= win_id;
            if (win_id == ID_W'(NUM_REQ - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= win_id + 1'b1;
            end
          end
          state <= ST_IDLE;
        end
        ST_CLEAR: begin
          clear_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dff_reg_en_clr #(
    .WIDTH(DATA_W)
  ) u_reg (
    .clk   (clk),
    .rst_n (async_reset_n),
    .clr   (clr_en),
    .en    (load_en),
    .d     (load_data),
    .q     (reg_q)
  );

endmodule
